alu_seq: RTL and testbench

Parametrised, handshaked successor to the processor's combinational 16-bit ALU. It adds:
- a registered single-cycle datapath for the existing operations;
- iterative multi-cycle multiply, divide and remainder;
- carry, overflow and divide-by-zero flags;
- valid/ready flow control on both sides.

It sits between the decode/register-read stage and writeback, and can stall the pipeline while an iterative operation runs.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_muldiv_iter.sv | 90 +++++++++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and op classification for alu_seq
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_NOT  = 4'd2,
    OP_SHL  = 4'd3,
    OP_SHR  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_SEQ  = 4'd7,
    OP_SLTU = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIVU = 4'd10,
    OP_REMU = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Divide by zero resolves in one cycle, so only a real divide goes iterative.
  function automatic logic is_iterative(logic [3:0] op, logic b_zero);
    return (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - one-bit-per-cycle shift-add multiply and restoring divide
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  // acc: partial product or partial remainder; x: multiplicand or dividend/quotient; y: multiplier or divisor
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, mul_q, mul_d, rem_q, rem_d;
  logic [WIDTH:0]   rtrial, rdiff;
  logic             ge;

  always_comb begin
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    mul_d  = mul_q;
    rem_d  = rem_q;
    rtrial = {acc_q, x_q[WIDTH-1]};
    rdiff  = rtrial - {1'b0, y_q};
    ge     = (rtrial >= {1'b0, y_q});
    if (start) begin
      acc_d  = '0;
      x_d    = a;
      y_d    = b;
      cnt_d  = CW'(WIDTH - 1);
      busy_d = 1'b1;
      mul_d  = (op == OP_MUL);
      rem_d  = (op == OP_REMU);
    end else if (busy_q) begin
      if (mul_q) begin
        if (y_q[0]) acc_d = acc_q + x_q;
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end else begin
        acc_d = ge ? rdiff[WIDTH-1:0] : rtrial[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], ge};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mul_q  <= 1'b0;
      rem_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mul_q  <= mul_d;
      rem_q  <= rem_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = (mul_q || rem_q) ? acc_q : x_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered single-cycle ops and iterative mul/div
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;
  logic             accept, b_zero, iter_op, sh_big;
  logic             mdu_busy, mdu_done;
  logic [WIDTH-1:0] mdu_res, sc_res;
  logic             sc_carry, sc_ovf, sc_dz;
  logic [WIDTH:0]   sum, diff;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign b_zero   = (b == '0);
  assign iter_op  = is_iterative(op, b_zero);
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign sh_big   = |(b >> SHW);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && iter_op),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (mdu_busy),
    .done  (mdu_done),
    .res   (mdu_res)
  );

  // Codes 12-15 and ADD share the default branch.
  always_comb begin
    sc_res   = sum[WIDTH-1:0];
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dz    = 1'b0;
    case (op)
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  sc_res = ~a;
      OP_SHL:  sc_res = sh_big ? '0 : (a << b[SHW-1:0]);
      OP_SHR:  sc_res = sh_big ? '0 : (a >> b[SHW-1:0]);
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_SEQ:  sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL:  sc_res = '0;
      OP_DIVU: begin
        sc_res = '1;
        sc_dz  = b_zero;
      end
      OP_REMU: begin
        sc_res = a;
        sc_dz  = b_zero;
      end
      default: begin
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    case (state_q)
      BUSY: begin
        if (mdu_done && !mdu_busy) begin
          state_d  = DONE;
          result_d = mdu_res;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          dz_d     = 1'b0;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: ;
    endcase
    // A new op accepted while the old result is consumed overrides DONE -> IDLE.
    if (accept) begin
      if (iter_op) begin
        state_d = BUSY;
      end else begin
        state_d  = DONE;
        result_d = sc_res;
        carry_d  = sc_carry;
        ovf_d    = sc_ovf;
        dz_d     = sc_dz;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq: vector table, hand sequences, random vs model
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic         zero, carry, ovf, dz;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  // edges: clock edges from the accept edge (inclusive) until out_valid is seen
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         o;
    logic         d;
    int           edges;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    logic         d;
    int           edges;
  } exp_t;

  function automatic exp_t model(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y);
    exp_t   e;
    longint m, ux, uy, sx, sy, t;
    m  = longint'(1) << W;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.c = 1'b0; e.o = 1'b0; e.d = 1'b0; e.edges = 1;
    case (o)
      4'd1: begin
        t     = ux - uy;
        e.res = W'((t % m + m) % m);
        e.c   = (ux < uy);
        e.o   = ((sx - sy) > (m / 2 - 1)) || ((sx - sy) < -(m / 2));
      end
      4'd2: e.res = W'(m - 1 - ux);
      4'd3: e.res = (uy >= W) ? '0 : W'((ux << uy) % m);
      4'd4: e.res = (uy >= W) ? '0 : W'(ux >> uy);
      4'd5: e.res = x & y;
      4'd6: e.res = x | y;
      4'd7: e.res = (ux == uy) ? W'(1) : W'(0);
      4'd8: e.res = (ux < uy) ? W'(1) : W'(0);
      4'd9: begin
        e.res = W'((ux * uy) % m);
        e.edges = W + 2;
      end
      4'd10, 4'd11: begin
        if (uy == 0) begin
          e.res = (o == 4'd10) ? W'(m - 1) : x;
          e.d   = 1'b1;
        end else begin
          e.res = (o == 4'd10) ? W'(ux / uy) : W'(ux % uy);
          e.edges = W + 2;
        end
      end
      default: begin
        t     = ux + uy;
        e.res = W'(t % m);
        e.c   = (t >= m);
        e.o   = ((sx + sy) > (m / 2 - 1)) || ((sx + sy) < -(m / 2));
      end
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one op, waits for acceptance and for its result; inputs are scrambled after accept.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic [3:0] f, output int lat);
    int guard;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    f = {carry, ovf, dz, zero};
  endtask

  initial begin
    vec_t         tbl[16];
    exp_t         e;
    logic [W-1:0] r, x, y;
    logic [3:0]   f, o;
    int           lat, bad, sel;

    tbl[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1};
    tbl[1]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    tbl[2]  = '{4'd1,  16'd3,    16'd5,    16'hFFFE, 1'b1, 1'b0, 1'b0, 1};
    tbl[3]  = '{4'd3,  16'h0001, 16'd15,   16'h8000, 1'b0, 1'b0, 1'b0, 1};
    tbl[4]  = '{4'd3,  16'h0001, 16'd16,   16'h0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{4'd4,  16'h8000, 16'd4,    16'h0800, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{4'd7,  16'd5,    16'd5,    16'h0001, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{4'd8,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{4'd9,  16'd300,  16'd300,  16'h5F90, 1'b0, 1'b0, 1'b0, 18};
    tbl[9]  = '{4'd10, 16'd1000, 16'd7,    16'd142,  1'b0, 1'b0, 1'b0, 18};
    tbl[10] = '{4'd11, 16'd1000, 16'd7,    16'd6,    1'b0, 1'b0, 1'b0, 18};
    tbl[11] = '{4'd10, 16'd5,    16'd0,    16'hFFFF, 1'b0, 1'b0, 1'b1, 1};
    tbl[12] = '{4'd11, 16'd5,    16'd0,    16'd5,    1'b0, 1'b0, 1'b1, 1};
    tbl[13] = '{4'd13, 16'd1,    16'd2,    16'd3,    1'b0, 1'b0, 1'b0, 1};
    tbl[14] = '{4'd2,  16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0, 1};
    tbl[15] = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry, ovf, dz, zero}, 4'b0001);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, f, lat);
      check($sformatf("vec%0d_res", i), r, tbl[i].res);
      check($sformatf("vec%0d_flags", i), f, {tbl[i].c, tbl[i].o, tbl[i].d, (tbl[i].res == '0)});
      check($sformatf("vec%0d_lat", i), lat, tbl[i].edges);
    end

    // Back-pressure: result and flags held, no acceptance, then consume and accept on one edge.
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(4'd1, 16'd3, 16'd5, r, f, lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result !== 16'hFFFE || {carry, ovf, dz, zero} !== 4'b1000 || !out_valid || in_ready) bad++;
    end
    check("bp_hold", bad, 0);
    @(negedge clk);
    op = 4'd0; a = 16'd1; b = 16'd1; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("bp_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_valid", out_valid, 1);
    check("bp_new_res", result, 16'd2);

    // Single-cycle ops back to back, one per clock.
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op = 4'd0; a = W'(i * 100); b = 16'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      if (!out_valid || result !== W'(i * 100 + 7)) bad++;
    end
    in_valid = 1'b0;
    check("thru_b2b", bad, 0);

    // MUL: stalled input stays pending through BUSY, result exactly 17 edges after accept.
    @(negedge clk);
    op = 4'd9; a = 16'd300; b = 16'd300; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'd0; a = 16'd1; b = 16'd1;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (out_valid || in_ready) bad++;
    end
    check("mul_busy_stall", bad, 0);
    @(posedge clk); #1;
    check("mul_valid_e17", out_valid, 1);
    check("mul_res", result, 16'h5F90);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mul_next_res", result, 16'd2);

    // Reset during cycle 8 of a MUL.
    @(negedge clk);
    op = 4'd9; a = 16'd300; b = 16'd300; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_zero", zero, 1);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("mid_rst_no_stale", bad, 0);
    run_op(4'd0, 16'd2, 16'd2, r, f, lat);
    check("post_rst_res", r, 16'd4);
    check("post_rst_lat", lat, 1);

    for (int i = 0; i < 150; i++) begin
      o   = 4'($urandom_range(0, 15));
      x   = W'($urandom);
      sel = $urandom_range(0, 3);
      y   = (sel == 0) ? '0 : (sel == 1) ? W'($urandom_range(0, 20)) : W'($urandom);
      e   = model(o, x, y);
      run_op(o, x, y, r, f, lat);
      check($sformatf("rnd%0d_op%0d_res", i, o), r, e.res);
      check($sformatf("rnd%0d_op%0d_flags", i, o), f, {e.c, e.o, e.d, (e.res == '0)});
      check($sformatf("rnd%0d_op%0d_lat", i, o), lat, e.edges);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
